// File: rtl/usb_pll_pkg.sv
// Shared types and default timing constants for the USB PLL lock sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package usb_pll_pkg;

  localparam int DEF_RST_CYCLES          = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES         = 3;

  // One-hot encoding: every output is a single state bit or an OR of two,
  // so the reset pins driven off-chip never see a decode glitch.
  typedef enum logic [4:0] {
    ST_HOLD   = 5'b00001,
    ST_WAIT   = 5'b00010,
    ST_STABLE = 5'b00100,
    ST_RUN    = 5'b01000,
    ST_FAIL   = 5'b10000
  } state_t;

  localparam int HOLD_BIT = 0;
  localparam int RUN_BIT  = 3;
  localparam int FAIL_BIT = 4;

  // Retry counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/usb_pll_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into clk.
// Latency: 2 clk cycles from input change to o_q.
// Backpressure: none (level signal, always accepted).
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops; both clear to 0 on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/usb_pll_ctrl.sv
// PLL reset/lock sequencer gating the 12 MHz USB domain reset (optional USB_PLL_AUTO_RELOCK_EN).
// Latency: outputs decode directly from state; pll_lock reaches the FSM after 2 cycles.
// Backpressure: none; force_relock is a one-cycle request taking priority over everything.
module usb_pll_ctrl
  import usb_pll_pkg::*;
#(
  parameter int RST_CYCLES          = DEF_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       usb_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  state_t           r_state, w_state_nxt;
  logic [RST_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic [STB_W-1:0] r_stb_cnt, w_stb_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [3:0]       r_retry, w_retry_nxt;
  logic [3:0]       w_retry_inc;
  logic             w_lock_s;
  logic             w_stable_done;
  logic             w_timeout;

  sync2 u_sync2 (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // State and counter registers; reset lands in HOLD with everything cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_HOLD;
      r_rst_cnt <= '0;
      r_stb_cnt <= '0;
      r_to_cnt  <= '0;
      r_retry   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_stb_cnt <= w_stb_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_retry   <= w_retry_nxt;
    end
  end

  // Next-state and counter logic; force_relock overrides every transition.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_stb_cnt_nxt = r_stb_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_retry_nxt   = r_retry;
    w_retry_inc   = sat_inc4(r_retry);
    w_stable_done = 1'b0;
    w_timeout     = 1'b0;

    if (force_relock) begin
      w_state_nxt   = ST_HOLD;
      w_rst_cnt_nxt = '0;
      w_stb_cnt_nxt = '0;
      w_to_cnt_nxt  = '0;
      w_retry_nxt   = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_rst_cnt == RST_LAST) begin
            w_state_nxt   = ST_WAIT;
            w_rst_cnt_nxt = '0;
            w_stb_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
          end
        end

        ST_WAIT, ST_STABLE: begin
          w_to_cnt_nxt  = r_to_cnt + TO_W'(1);
          w_stable_done = (r_state == ST_STABLE) && w_lock_s && (r_stb_cnt == STB_LAST);
          w_timeout     = (r_to_cnt == TO_LAST);
          // A lock that completes on the timeout cycle is still a good lock.
          if (w_stable_done) begin
            w_state_nxt   = ST_RUN;
            w_stb_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
          end else if (w_timeout) begin
            w_retry_nxt   = w_retry_inc;
            w_state_nxt   = (w_retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
            w_stb_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
          end else if (r_state == ST_STABLE) begin
            if (w_lock_s) begin
              w_stb_cnt_nxt = r_stb_cnt + STB_W'(1);
            end else begin
              w_stb_cnt_nxt = '0;
              w_state_nxt   = ST_WAIT;
            end
          end else if (w_lock_s) begin
            w_state_nxt   = ST_STABLE;
            w_stb_cnt_nxt = '0;
          end
        end

        ST_RUN: begin
          if (!w_lock_s) begin
`ifdef USB_PLL_AUTO_RELOCK_EN
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
`else
            w_state_nxt = ST_FAIL;
`endif
          end
        end

        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end

        default: begin
          w_state_nxt   = ST_HOLD;
          w_rst_cnt_nxt = '0;
          w_stb_cnt_nxt = '0;
          w_to_cnt_nxt  = '0;
        end
      endcase
    end
  end

  assign pll_reset = r_state[HOLD_BIT] | r_state[FAIL_BIT];
  assign usb_rst_n = r_state[RUN_BIT];
  assign ready     = r_state[RUN_BIT];
  assign fail      = r_state[FAIL_BIT];
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_usb_pll_ctrl.sv
// Directed bench for usb_pll_ctrl with short timing parameters.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_usb_pll_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_reset;
  logic       usb_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;

  usb_pll_ctrl #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .force_relock (force_relock),
    .pll_reset    (pll_reset),
    .usb_rst_n    (usb_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       lk;
    logic       fr;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output word: {pll_reset, usb_rst_n, ready, fail, retry_cnt}.
  function automatic logic [7:0] E(input logic pr, input logic ur, input logic rd,
                                   input logic fl, input int rt);
    return {pr, ur, rd, fl, 4'(rt)};
  endfunction

  function automatic logic [7:0] outs();
    return {pll_reset, usb_rst_n, ready, fail, retry_cnt};
  endfunction

  task automatic add(input logic rn, input logic lk, input logic fr, input int n,
                     input logic [7:0] exp);
    vec_t v;
    v.rn = rn; v.lk = lk; v.fr = fr; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {pll_reset,usb_rst_n,ready,fail,retry}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
               nm, act[7], act[6], act[5], act[4], act[3:0],
               exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit so sampling is off-edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    pll_lock     = 1'b1;
    force_relock = 1'b0;

    // Clean start with lock present: HOLD 4, WAIT 1, STABLE 8, then RUN at edge 13.
    add(0, 1, 0, 2,  E(1, 0, 0, 0, 0));   // in reset
    add(1, 1, 0, 3,  E(1, 0, 0, 0, 0));   // edge 3: still HOLD
    add(1, 1, 0, 1,  E(0, 0, 0, 0, 0));   // edge 4: WAIT
    add(1, 1, 0, 8,  E(0, 0, 0, 0, 0));   // edge 12: STABLE
    add(1, 1, 0, 1,  E(0, 1, 1, 0, 0));   // edge 13: RUN
    add(1, 1, 0, 20, E(0, 1, 1, 0, 0));   // RUN holds
    // Lock loss in RUN: state reacts on the 3rd edge after pll_lock drops.
    add(1, 0, 0, 2,  E(0, 1, 1, 0, 0));
`ifdef USB_PLL_AUTO_RELOCK_EN
    add(1, 0, 0, 1,  E(1, 0, 0, 0, 1));   // HOLD, retry 1
    add(1, 1, 0, 4,  E(0, 0, 0, 0, 1));   // WAIT
    add(1, 1, 0, 9,  E(0, 1, 1, 0, 1));   // relocked, retry kept
`else
    add(1, 0, 0, 1,  E(1, 0, 0, 1, 0));   // FAIL, retry unchanged
    add(1, 1, 0, 4,  E(1, 0, 0, 1, 0));   // sticky despite lock
    add(1, 1, 0, 9,  E(1, 0, 0, 1, 0));
`endif
    // force_relock restarts the full sequence from any state.
    add(1, 1, 1, 1,  E(1, 0, 0, 0, 0));
    add(1, 1, 0, 3,  E(1, 0, 0, 0, 0));
    add(1, 1, 0, 1,  E(0, 0, 0, 0, 0));
    add(1, 1, 0, 8,  E(0, 0, 0, 0, 0));
    add(1, 1, 0, 1,  E(0, 1, 1, 0, 0));
    // No lock at all: two HOLD(4)/WAIT(32) attempts, then sticky FAIL.
    add(0, 0, 0, 2,  E(1, 0, 0, 0, 0));
    add(1, 0, 0, 4,  E(0, 0, 0, 0, 0));   // edge 4: WAIT
    add(1, 0, 0, 31, E(0, 0, 0, 0, 0));   // edge 35: last WAIT cycle
    add(1, 0, 0, 1,  E(1, 0, 0, 0, 1));   // edge 36: timeout -> HOLD
    add(1, 0, 0, 3,  E(1, 0, 0, 0, 1));
    add(1, 0, 0, 1,  E(0, 0, 0, 0, 1));   // edge 40: WAIT
    add(1, 0, 0, 31, E(0, 0, 0, 0, 1));
    add(1, 0, 0, 1,  E(1, 0, 0, 1, 2));   // edge 72: FAIL
    add(1, 0, 0, 40, E(1, 0, 0, 1, 2));   // sticky

    for (int i = 0; i < tbl.size(); i++) begin
      resetn       = tbl[i].rn;
      pll_lock     = tbl[i].lk;
      force_relock = tbl[i].fr;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Glitch mid-STABLE from FAIL recovery: one low cycle pushes RUN from F+13 to F+20.
    force_relock = 1'b1; pll_lock = 1'b1;
    step(1);                              // F: HOLD
    chk("relock_hold", E(1, 0, 0, 0, 0));
    force_relock = 1'b0;
    step(7);                              // F+8: STABLE
    chk("relock_stable", E(0, 0, 0, 0, 0));
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(4);                              // F+13: would be RUN without glitch
    chk("glitch_no_run", E(0, 0, 0, 0, 0));
    step(6);                              // F+19
    chk("glitch_pre_run", E(0, 0, 0, 0, 0));
    step(1);                              // F+20
    chk("glitch_run", E(0, 1, 1, 0, 0));

    // Asynchronous reset in WAIT after one timeout, then a clean restart.
    force_relock = 1'b1; pll_lock = 1'b0;
    step(1);
    force_relock = 1'b0;
    step(44);                             // F+45: WAIT of second attempt
    chk("mid_wait", E(0, 0, 0, 0, 1));
    #2 resetn = 1'b0;
    #1;
    chk("async_reset", E(1, 0, 0, 0, 0));
    pll_lock = 1'b1;
    step(2);
    chk("reset_held", E(1, 0, 0, 0, 0));
    resetn = 1'b1;
    step(3);
    chk("restart_hold", E(1, 0, 0, 0, 0));
    step(1);
    chk("restart_wait", E(0, 0, 0, 0, 0));
    step(8);
    chk("restart_stable", E(0, 0, 0, 0, 0));
    step(1);
    chk("restart_run", E(0, 1, 1, 0, 0));

    // Stable completion on the same edge as timeout (W+32) must enter RUN.
    force_relock = 1'b1; pll_lock = 1'b0;
    step(1);                              // F: HOLD, WAIT from F+4
    force_relock = 1'b0;
    step(24);                             // F+25
    pll_lock = 1'b1;                      // lock_s high after F+27, STABLE at F+28
    step(10);                             // F+35
    chk("tie_pre", E(0, 0, 0, 0, 0));
    step(1);                              // F+36: stable done and timeout
    chk("tie_run", E(0, 1, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
